dbus_core_port: RTL

- Per-core request adapter directly upstream of the multi-core data-bus/dmem arbiter; one instance per core, outputs packed into the arbiter's per-core lanes.
- Accepts one load/store/LR/SC from the core's memory stage via valid/ready.
- Converts the byte address to a word address plus write strobes, holds the bus request stable while the arbiter stalls it, waits the fixed read latency, and returns a registered response.

---
 rtl/dbus_core_port_if.sv | 47 ++++
 rtl/dbus_core_port.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dbus_core_port_if.sv
// Core-side request/response and arbiter-lane signals of one dbus_core_port.
// Zero latency; slave modport is the port's own view, master is the core/arbiter side.
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 12
`endif

interface dbus_core_port_if #(
  parameter int DMEM_ADDRW = `DMEM_ADDRW
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [DMEM_ADDRW+1:0] req_addr_i;
  logic [31:0]           req_wdata_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic                  req_lr_i;
  logic                  req_sc_i;
  logic                  resp_valid_o;
  logic [31:0]           resp_rdata_o;
  logic                  resp_err_o;
  logic                  bus_re_o;
  logic                  bus_we_o;
  logic [DMEM_ADDRW-1:0] bus_addr_o;
  logic [31:0]           bus_wdata_o;
  logic [3:0]            bus_wstrb_o;
  logic                  bus_is_lr_o;
  logic                  bus_is_sc_o;
  logic [31:0]           bus_rdata_i;
  logic                  bus_stall_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
           req_unsigned_i, req_lr_i, req_sc_i, bus_rdata_i, bus_stall_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           bus_re_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
           bus_is_lr_o, bus_is_sc_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
           req_unsigned_i, req_lr_i, req_sc_i, bus_rdata_i, bus_stall_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           bus_re_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
           bus_is_lr_o, bus_is_sc_o
  );
endinterface

// File: rtl/dbus_core_port.sv
// Per-core load/store/LR/SC adapter feeding one arbiter lane; DBUS_PORT_LOAD_EXT_EN adds load extraction.
// Latency: response RD_LAT+1 cycles after grant (T+3 unstalled, RD_LAT=1); errors respond at T+1.
// Backpressure: one request outstanding, bus request held stable under stall, response never stalled.
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 12
`endif

module dbus_core_port #(
  parameter int DMEM_ADDRW = `DMEM_ADDRW,
  parameter int RD_LAT     = 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  dbus_core_port_if.slave   io
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;

  state_t      state;
  logic [1:0]  lat_cnt;
  logic        illegal;
  logic [3:0]  map_strb;
  logic [31:0] map_wdata;
  logic [31:0] rdata_fmt;

`ifdef DBUS_PORT_LOAD_EXT_EN
  logic        lat_we;
  logic        lat_uns;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic [31:0] rd_shift;
`endif

  always_comb begin
    illegal = (io.req_size_i == 2'd3)
            | ((io.req_size_i == 2'd1) & io.req_addr_i[0])
            | ((io.req_size_i == 2'd2) & (io.req_addr_i[1:0] != 2'b00))
            | ((io.req_lr_i | io.req_sc_i) & (io.req_size_i != 2'd2))
            | (io.req_lr_i & io.req_sc_i)
            | (io.req_lr_i & io.req_we_i)
            | (io.req_sc_i & ~io.req_we_i);
    case (io.req_size_i)
      2'd0: begin
        map_strb  = 4'b0001 << io.req_addr_i[1:0];
        map_wdata = {4{io.req_wdata_i[7:0]}};
      end
      2'd1: begin
        map_strb  = 4'b0011 << io.req_addr_i[1:0];
        map_wdata = {2{io.req_wdata_i[15:0]}};
      end
      default: begin
        map_strb  = 4'b1111;
        map_wdata = io.req_wdata_i;
      end
    endcase
    if (!io.req_we_i) begin
      map_strb  = 4'b0000;
      map_wdata = 32'h0;
    end
  end

  always_comb begin
    rdata_fmt = io.bus_rdata_i;
`ifdef DBUS_PORT_LOAD_EXT_EN
    rd_shift = io.bus_rdata_i >> {lat_off, 3'b000};
    // LR is always an aligned word, so it falls through to the full-word case.
    if (!lat_we) begin
      case (lat_size)
        2'd0:    rdata_fmt = lat_uns ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
        2'd1:    rdata_fmt = lat_uns ? {16'h0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
        default: rdata_fmt = rd_shift;
      endcase
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= S_IDLE;
      lat_cnt         <= 2'd0;
      io.req_ready_o  <= 1'b1;
      io.resp_valid_o <= 1'b0;
      io.resp_rdata_o <= 32'h0;
      io.resp_err_o   <= 1'b0;
      io.bus_re_o     <= 1'b0;
      io.bus_we_o     <= 1'b0;
      io.bus_addr_o   <= '0;
      io.bus_wdata_o  <= 32'h0;
      io.bus_wstrb_o  <= 4'h0;
      io.bus_is_lr_o  <= 1'b0;
      io.bus_is_sc_o  <= 1'b0;
`ifdef DBUS_PORT_LOAD_EXT_EN
      lat_we          <= 1'b0;
      lat_uns         <= 1'b0;
      lat_size        <= 2'd0;
      lat_off         <= 2'd0;
`endif
    end else begin
      io.resp_valid_o <= 1'b0;
      io.resp_err_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (io.req_valid_i) begin
            io.req_ready_o <= 1'b0;
`ifdef DBUS_PORT_LOAD_EXT_EN
            lat_we   <= io.req_we_i;
            lat_uns  <= io.req_unsigned_i;
            lat_size <= io.req_size_i;
            lat_off  <= io.req_addr_i[1:0];
`endif
            if (illegal) begin
              state           <= S_ERR;
              io.resp_valid_o <= 1'b1;
              io.resp_err_o   <= 1'b1;
              io.resp_rdata_o <= 32'h0;
            end else begin
              state          <= S_ISSUE;
              io.bus_re_o    <= ~io.req_we_i;
              io.bus_we_o    <= io.req_we_i;
              io.bus_addr_o  <= io.req_addr_i[DMEM_ADDRW+1:2];
              io.bus_wdata_o <= map_wdata;
              io.bus_wstrb_o <= map_strb;
              io.bus_is_lr_o <= io.req_lr_i;
              io.bus_is_sc_o <= io.req_sc_i;
            end
          end
        end
        S_ISSUE: begin
          // The first unstalled cycle is the grant; the request drops right after it.
          if (!io.bus_stall_i) begin
            state          <= S_WAIT;
            lat_cnt        <= 2'(RD_LAT - 1);
            io.bus_re_o    <= 1'b0;
            io.bus_we_o    <= 1'b0;
            io.bus_wstrb_o <= 4'h0;
            io.bus_is_lr_o <= 1'b0;
            io.bus_is_sc_o <= 1'b0;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state           <= S_RESP;
            io.resp_valid_o <= 1'b1;
            io.resp_rdata_o <= rdata_fmt;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_RESP, S_ERR: begin
          state          <= S_IDLE;
          io.req_ready_o <= 1'b1;
        end
        default: begin
          state          <= S_IDLE;
          io.req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
